// File: rtl/keypad_debouncer.sv
// -----------------------------------------------------------------------------
// keypad_debouncer
//
// Debounces a 10-key numeric keypad and presents one clean, accepted key at a
// time to the downstream input encoder.
//
// A single key is accepted only after DEBOUNCE_CYCLES consecutive identical
// samples. It is released only after DEBOUNCE_CYCLES consecutive all-zero
// samples. A press that involves more than one key is rejected. The keypad
// must then be quiet for DEBOUNCE_CYCLES samples before a new press is
// considered.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive identical samples needed to accept a press
//                     or a release (2..255).
//   CNT_W           : width of the stability counter.
//
// Ports
//   clk        in   1   single clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   key_raw    in  10   raw, bouncy key contacts (bit n = digit n pressed)
//   key_onehot out 10   clean one-hot key, held for the whole accepted press
//   digit      out  4   binary value of the accepted key, 0 when none held
//   key_valid  out  1   one-cycle pulse per accepted press
//   multi_err  out  1   one-cycle pulse when a multi-key press is rejected
//   busy       out  1   high whenever the FSM is not idle
//
// Build option
//   KEYPAD_SYNC_EN : when defined, key_raw passes through a two-flop
//                    synchronizer before the FSM. This adds two cycles to
//                    both press and release latency. The port list does not
//                    change.
// -----------------------------------------------------------------------------
module keypad_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] key_raw,
    output logic [9:0] key_onehot,
    output logic [3:0] digit,
    output logic       key_valid,
    output logic       multi_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_RELEASE,
        REJECT
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [9:0]       cand, cand_nxt;
    logic [9:0]       onehot_nxt;
    logic [3:0]       digit_nxt;
    logic             valid_nxt;
    logic             merr_nxt;
    logic [9:0]       sample;

    // True when exactly one bit is set.
    function automatic logic is_single(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    // True when two or more bits are set.
    function automatic logic is_multi(input logic [9:0] v);
        return (v & (v - 10'd1)) != 10'd0;
    endfunction

    // Binary index of a one-hot key.
    function automatic logic [3:0] encode(input logic [9:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Increment that saturates at the debounce limit, so it never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= LIMIT) ? LIMIT : c + ONE;
    endfunction

`ifdef KEYPAD_SYNC_EN
    // Two-flop synchronizer stage ahead of the FSM
    logic [9:0] key_sync_p0, key_sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_sync_p0 <= 10'd0;
            key_sync_p1 <= 10'd0;
        end else begin
            key_sync_p0 <= key_raw;
            key_sync_p1 <= key_sync_p0;
        end
    end

    assign sample = key_sync_p1;
`else
    assign sample = key_raw;
`endif

    // FSM and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            cand       <= 10'd0;
            key_onehot <= 10'd0;
            digit      <= 4'd0;
            key_valid  <= 1'b0;
            multi_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            cand       <= cand_nxt;
            key_onehot <= onehot_nxt;
            digit      <= digit_nxt;
            key_valid  <= valid_nxt;
            multi_err  <= merr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        cand_nxt   = cand;
        onehot_nxt = key_onehot;
        digit_nxt  = digit;
        valid_nxt  = 1'b0;
        merr_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (is_single(sample)) begin
                    state_nxt = DB_PRESS;
                    cand_nxt  = sample;
                    count_nxt = ONE;
                end else if (is_multi(sample)) begin
                    state_nxt = REJECT;
                    cand_nxt  = 10'd0;
                    count_nxt = '0;
                    merr_nxt  = 1'b1;
                end
            end

            DB_PRESS: begin
                if (sample == cand) begin
                    count_nxt = sat_inc(count);
                    // Accept the press. key_valid is registered, so it is
                    // high only during the following cycle.
                    if (sat_inc(count) == LIMIT) begin
                        state_nxt  = HELD;
                        count_nxt  = '0;
                        onehot_nxt = cand;
                        digit_nxt  = encode(cand);
                        valid_nxt  = 1'b1;
                    end
                end else if (sample == 10'd0) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                    cand_nxt  = 10'd0;
                end else if (is_single(sample)) begin
                    cand_nxt  = sample;
                    count_nxt = ONE;
                end else begin
                    state_nxt = REJECT;
                    cand_nxt  = 10'd0;
                    count_nxt = '0;
                    merr_nxt  = 1'b1;
                end
            end

            HELD: begin
                // Outputs stay put here. Any deviation only starts the
                // release timer.
                if (sample != cand) begin
                    state_nxt = DB_RELEASE;
                    count_nxt = ONE;
                end
            end

            DB_RELEASE: begin
                if (sample == 10'd0) begin
                    count_nxt = sat_inc(count);
                    if (sat_inc(count) == LIMIT) begin
                        state_nxt  = IDLE;
                        count_nxt  = '0;
                        cand_nxt   = 10'd0;
                        onehot_nxt = 10'd0;
                        digit_nxt  = 4'd0;
                    end
                end else if (sample == cand) begin
                    state_nxt = HELD;
                    count_nxt = '0;
                end else begin
                    count_nxt = '0;
                end
            end

            REJECT: begin
                if (sample == 10'd0) begin
                    count_nxt = sat_inc(count);
                    if (sat_inc(count) == LIMIT) begin
                        state_nxt = IDLE;
                        count_nxt = '0;
                    end
                end else begin
                    count_nxt = '0;
                end
            end

            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_keypad_debouncer.sv
// -----------------------------------------------------------------------------
// tb_keypad_debouncer
//
// Randomized self-checking bench for keypad_debouncer (DEBOUNCE_CYCLES = 4).
// A behavioural reference model tracks the accepted key, the pending
// candidate and the run length of qualifying samples. It predicts every
// output after every clock edge. Directed scenarios from the keypad
// requirements are mixed with random press, bounce, multi-key, noise and
// reset traffic.
//
// If KEYPAD_SYNC_EN is defined, the model delays its input by two samples.
// -----------------------------------------------------------------------------
module tb_keypad_debouncer;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic [9:0] key_raw;
    logic [9:0] key_onehot;
    logic [3:0] digit;
    logic       key_valid;
    logic       multi_err;
    logic       busy;

    keypad_debouncer #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (key_raw),
        .key_onehot(key_onehot),
        .digit     (digit),
        .key_valid (key_valid),
        .multi_err (multi_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_no = 0;
    int vld_seen = 0;

    // Reference model state
    int         m_held = -1;   // accepted key index, -1 when none
    int         m_cand = -1;   // key being qualified, -1 when none
    bit         m_rel = 0;     // accepted key is being released
    bit         m_rej = 0;     // waiting out a rejected multi-key press
    int         m_run = 0;     // length of the current qualifying run
    bit         m_vld = 0;
    bit         m_merr = 0;
    logic [9:0] m_dl0 = '0;
    logic [9:0] m_dl1 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc_no, got, exp);
        end
    endtask

    function automatic int key_idx(input logic [9:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 10; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Advance the model by one sampling edge, given the value the FSM sees.
    task automatic model_step(input logic [9:0] s, input logic r);
        int n;
        n = $countones(s);
        m_vld = 0;
        m_merr = 0;
        if (r) begin
            m_held = -1; m_cand = -1; m_rel = 0; m_rej = 0; m_run = 0;
        end else if (m_rej) begin
            m_run = (s == 10'd0) ? m_run + 1 : 0;
            if (m_run >= N) begin
                m_rej = 0; m_run = 0;
            end
        end else if (m_held >= 0) begin
            if (!m_rel) begin
                if (s != (10'd1 << m_held)) begin
                    m_rel = 1; m_run = 1;
                end
            end else if (s == 10'd0) begin
                m_run++;
                if (m_run >= N) begin
                    m_held = -1; m_rel = 0; m_run = 0;
                end
            end else if (s == (10'd1 << m_held)) begin
                m_rel = 0; m_run = 0;
            end else begin
                m_run = 0;
            end
        end else if (m_cand >= 0) begin
            if (n == 0) begin
                m_cand = -1; m_run = 0;
            end else if (n > 1) begin
                m_cand = -1; m_rej = 1; m_run = 0; m_merr = 1;
            end else if (key_idx(s) == m_cand) begin
                m_run++;
                if (m_run >= N) begin
                    m_held = m_cand; m_cand = -1; m_run = 0; m_vld = 1;
                end
            end else begin
                m_cand = key_idx(s); m_run = 1;
            end
        end else begin
            if (n == 1) begin
                m_cand = key_idx(s); m_run = 1;
            end else if (n > 1) begin
                m_rej = 1; m_run = 0; m_merr = 1;
            end
        end
    endtask

    // Apply one cycle of input, step the model on the edge, check on the
    // following falling edge.
    task automatic cyc(input logic [9:0] k, input logic r);
        logic [9:0] s;
        logic [9:0] e_onehot;
        key_raw = k;
        rst     = r;
        @(posedge clk);
`ifdef KEYPAD_SYNC_EN
        s = m_dl1;
        if (r) begin
            m_dl0 = '0; m_dl1 = '0;
        end else begin
            m_dl1 = m_dl0; m_dl0 = k;
        end
`else
        s = k;
`endif
        model_step(s, r);
        @(negedge clk);
        cyc_no++;
        e_onehot = (m_held >= 0) ? (10'd1 << m_held) : 10'd0;
        chk("key_onehot", 32'(key_onehot), 32'(e_onehot));
        chk("digit", 32'(digit), (m_held >= 0) ? 32'(m_held) : 32'd0);
        chk("key_valid", 32'(key_valid), 32'(m_vld));
        chk("multi_err", 32'(multi_err), 32'(m_merr));
        chk("busy", 32'(busy), 32'(m_rej || m_held >= 0 || m_cand >= 0));
        if (key_valid === 1'b1) vld_seen++;
    endtask

    task automatic repeat_cyc(input logic [9:0] k, input int len);
        for (int i = 0; i < len; i++) cyc(k, 1'b0);
    endtask

    function automatic logic [9:0] rand_key();
        return 10'd1 << $urandom_range(0, 9);
    endfunction

    initial begin
        int v0;
        logic [9:0] k, k2;
        int len;

        key_raw = '0;
        rst     = 1'b1;
        @(negedge clk);

        // Reset state
        cyc(10'd0, 1'b1);
        cyc(10'd0, 1'b1);
        chk("rst_onehot", 32'(key_onehot), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single clean press of digit 2, then release
        v0 = vld_seen;
        repeat_cyc(10'b0000000100, 8);
        chk("r027_digit", 32'(digit), 32'd2);
        repeat_cyc(10'd0, 8);
        chk("r027_pulses", 32'(vld_seen - v0), 32'd1);
        chk("r027_busy", 32'(busy), 32'd0);

        // Bouncy contact on digit 5, then a steady hold
        v0 = vld_seen;
        for (int i = 0; i < 10; i++) cyc((i % 2) ? 10'd0 : 10'b0000100000, 1'b0);
        chk("r028_bounce_pulses", 32'(vld_seen - v0), 32'd0);
        repeat_cyc(10'b0000100000, 8);
        chk("r028_pulses", 32'(vld_seen - v0), 32'd1);
        chk("r028_digit", 32'(digit), 32'd5);
        repeat_cyc(10'd0, 8);

        // Multi-key press is rejected
        v0 = vld_seen;
        repeat_cyc(10'b1000000010, 3);
        chk("r029_busy", 32'(busy), 32'd1);
        repeat_cyc(10'd0, 7);
        chk("r029_pulses", 32'(vld_seen - v0), 32'd0);
        chk("r029_idle", 32'(busy), 32'd0);

        // Long hold of digit 9 with a short dropout
        v0 = vld_seen;
        repeat_cyc(10'b1000000000, 9);
        for (int i = 0; i < 2; i++) begin
            cyc(10'd0, 1'b0);
            chk("r030_hold", 32'(key_onehot), 32'h200);
        end
        for (int i = 0; i < 9; i++) begin
            cyc(10'b1000000000, 1'b0);
            chk("r030_hold", 32'(key_onehot), 32'h200);
        end
        chk("r030_pulses", 32'(vld_seen - v0), 32'd1);
        repeat_cyc(10'd0, 8);

        // Reset in the middle of a debounce, key still held
        v0 = vld_seen;
        repeat_cyc(10'b0100000000, 2);
        cyc(10'b0100000000, 1'b1);
        chk("r031_rst_pulses", 32'(vld_seen - v0), 32'd0);
        repeat_cyc(10'b0100000000, 8);
        chk("r031_pulses", 32'(vld_seen - v0), 32'd1);
        repeat_cyc(10'd0, 8);

        // Random traffic
        for (int seg = 0; seg < 300; seg++) begin
            k = rand_key();
            case ($urandom_range(0, 9))
                0, 1: repeat_cyc(10'd0, $urandom_range(1, 8));
                2, 3, 4: repeat_cyc(k, $urandom_range(1, 9));
                5: begin
                    len = $urandom_range(2, 8);
                    for (int i = 0; i < len; i++) cyc((i % 2) ? 10'd0 : k, 1'b0);
                end
                6: begin
                    do k2 = rand_key(); while (k2 == k);
                    repeat_cyc(k | k2, $urandom_range(1, 3));
                end
                7: begin
                    len = $urandom_range(1, 3);
                    for (int i = 0; i < len; i++) cyc(10'($urandom()), 1'b0);
                end
                8: begin
                    k2 = rand_key();
                    repeat_cyc(k, $urandom_range(1, 6));
                    cyc(k2, 1'b0);
                    repeat_cyc(k, $urandom_range(1, 6));
                end
                default: begin
                    len = $urandom_range(1, 2);
                    for (int i = 0; i < len; i++) cyc(k, 1'b1);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
